// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 encodings,
// FSM state encoding and the decoded operation-flag record.
package mdu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    typedef struct packed {
        logic signed_a;
        logic signed_b;
        logic take_high;
        logic is_div;
        logic is_rem;
    } mdu_op_t;

    // Iteration counter width: enough to hold XLEN itself without wrapping.
    function automatic int unsigned mdu_cnt_width(input int unsigned xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/response bundle of the multiply/divide sequencer plus a debug view of its FSM.
interface mdu_sequencer_if #(parameter int XLEN = 32);
    import mdu_pkg::*;

    // start is taken only while busy=0; valid is a one-cycle pulse with result,
    // and result stays put until a later operation completes.
    logic            start;
    logic            abort;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;
    mdu_state_e      dbg_state;

    modport master (
        output start, abort, funct3, operand_a, operand_b,
        input  busy, valid, result, dbg_state
    );

    modport slave (
        input  start, abort, funct3, operand_a, operand_b,
        output busy, valid, result, dbg_state
    );

endinterface

// File: rtl/mdu_op_decoder.sv
// Maps an RV32M funct3 to the signedness / result-selection flags used by the datapath.
module mdu_op_decoder
    import mdu_pkg::*;
(
    input  logic [2:0] funct3_i,
    output mdu_op_t    op_o
);

    always_comb begin
        op_o = '0;
        case (funct3_i)
            F3_MUL:    ;
            F3_MULH:   begin op_o.signed_a = 1'b1; op_o.signed_b = 1'b1; op_o.take_high = 1'b1; end
            F3_MULHSU: begin op_o.signed_a = 1'b1; op_o.take_high = 1'b1; end
            F3_MULHU:  op_o.take_high = 1'b1;
            F3_DIV:    begin op_o.signed_a = 1'b1; op_o.signed_b = 1'b1; op_o.is_div = 1'b1; end
            F3_DIVU:   op_o.is_div = 1'b1;
            F3_REM:    begin op_o.signed_a = 1'b1; op_o.signed_b = 1'b1; op_o.is_div = 1'b1; op_o.is_rem = 1'b1; end
            F3_REMU:   begin op_o.is_div = 1'b1; op_o.is_rem = 1'b1; end
            default:   op_o = '0;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// shift-add multiply and restoring divide sharing one 2*XLEN working register.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FAST_SPECIAL = 1
) (
    input  logic           clock,
    input  logic           reset_n,
    mdu_sequencer_if.slave bus
);

    localparam int unsigned CW = mdu_cnt_width(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    mdu_state_e        state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] p_q;
    logic [XLEN-1:0]   addend_q;
    logic              is_div_q;
    logic              is_rem_q;
    logic              take_high_q;
    logic              neg_q;
    logic              special_q;
    logic [XLEN-1:0]   special_res_q;
    logic [XLEN-1:0]   result_q;
    logic              busy_q;
    logic              valid_q;

    mdu_op_t dec_op;

    mdu_op_decoder u_dec (
        .funct3_i (bus.funct3),
        .op_o     (dec_op)
    );

    // Accept-time decode of operands
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic            div_special;
    logic [XLEN-1:0] special_res;
    logic            neg_d;

    always_comb begin
        a_neg       = dec_op.signed_a & bus.operand_a[XLEN-1];
        b_neg       = dec_op.signed_b & bus.operand_b[XLEN-1];
        mag_a       = a_neg ? -bus.operand_a : bus.operand_a;
        mag_b       = b_neg ? -bus.operand_b : bus.operand_b;
        div_zero    = dec_op.is_div && (bus.operand_b == '0);
        div_ovf     = dec_op.is_div && dec_op.signed_a
                      && (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.operand_b == '1);
        div_special = div_zero || div_ovf;
        if (div_zero) begin
            special_res = dec_op.is_rem ? bus.operand_a : '1;
        end else begin
            special_res = dec_op.is_rem ? '0 : bus.operand_a;
        end
        // Remainder takes the dividend's sign; product and quotient take the XOR.
        neg_d = dec_op.is_rem ? a_neg : (a_neg ^ b_neg);
    end

    // One iteration of the active algorithm
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] p_step;

    always_comb begin
        mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, addend_q} : '0);
        div_sh   = p_q[2*XLEN-1:XLEN-1];
        div_diff = div_sh - {1'b0, addend_q};
        if (is_div_q) begin
            if (!div_diff[XLEN]) begin
                p_step = {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
            end else begin
                p_step = {div_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
            end
        end else begin
            p_step = {mul_sum, p_q[XLEN-1:1]};
        end
    end

    // Sign fixup applied to the final iteration's value on DONE entry
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_val;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_fix = neg_q ? -p_step : p_step;
        div_val  = is_rem_q ? p_step[2*XLEN-1:XLEN] : p_step[XLEN-1:0];
        if (special_q) begin
            fix_res = special_res_q;
        end else if (is_div_q) begin
            fix_res = neg_q ? -div_val : div_val;
        end else begin
            fix_res = take_high_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            p_q           <= '0;
            addend_q      <= '0;
            is_div_q      <= 1'b0;
            is_rem_q      <= 1'b0;
            take_high_q   <= 1'b0;
            neg_q         <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            result_q      <= '0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        is_div_q      <= dec_op.is_div;
                        is_rem_q      <= dec_op.is_rem;
                        take_high_q   <= dec_op.take_high;
                        neg_q         <= neg_d;
                        special_q     <= div_special;
                        special_res_q <= special_res;
                        addend_q      <= dec_op.is_div ? mag_b : mag_a;
                        p_q           <= {{XLEN{1'b0}}, (dec_op.is_div ? mag_a : mag_b)};
                        cnt_q         <= '0;
                        busy_q        <= 1'b1;
                        if ((FAST_SPECIAL != 0) && div_special) begin
                            state_q  <= ST_DONE;
                            valid_q  <= 1'b1;
                            result_q <= special_res;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        p_q <= p_step;
                        if (cnt_q == CNT_LAST) begin
                            state_q  <= ST_DONE;
                            valid_q  <= 1'b1;
                            result_q <= fix_res;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.result    = result_q;
    assign bus.dbg_state = state_q;

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving operand and result width.
REQ-002 SHALL have parameter FAST_SPECIAL, default 1; when 1, divide-by-zero and overflow cases bypass iteration.
REQ-003 SHALL have port clock  input  1  single system clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-006 SHALL have port abort  input  1  cancel in-flight operation.
REQ-007 SHALL have port funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port operand_a  input  XLEN  rs1 value / dividend.
REQ-009 SHALL have port operand_b  input  XLEN  rs2 value / divisor.
REQ-010 SHALL have port busy  output  1  operation in flight.
REQ-011 SHALL have port valid  output  1  one-cycle pulse, result is valid.
REQ-012 SHALL have port result  output  XLEN  operation result.

Function
REQ-013 SHALL capture funct3, operand_a and operand_b on the rising edge where start=1 and busy=0; later input changes SHALL NOT affect the operation.
REQ-014 SHALL ignore start while busy=1; no queuing.
REQ-015 SHALL implement states IDLE, RUN, DONE: IDLE->RUN on accepted start; RUN->DONE after XLEN iterations; DONE->IDLE unconditionally after one cycle.
REQ-016 SHALL assert busy in RUN and DONE, and deassert it in IDLE.
REQ-017 SHALL assert valid only in DONE, for exactly one cycle; valid rises XLEN+1 cycles after the start edge.
REQ-018 SHALL compute operations on operand magnitudes, using an iterative shift-add multiply (2*XLEN product) and a restoring divide, one bit per cycle, with sign fixup in DONE entry.
REQ-019 SHALL treat operands as signed/unsigned per op: MULH both signed; MULHSU a signed, b unsigned; MULHU, DIVU, REMU unsigned.
REQ-020 SHALL return product[XLEN-1:0] for MUL, product[2*XLEN-1:XLEN] for MULH*, the quotient for DIV*, and the remainder for REM*.
REQ-021 SHALL handle divide by zero as: quotient all ones, remainder = operand_a, for signed and unsigned.
REQ-022 SHALL handle signed overflow (operand_a = most negative, operand_b = -1) as: DIV result = operand_a, REM result = 0.
REQ-023 SHALL, when FAST_SPECIAL=1, take REQ-021/REQ-022 cases IDLE->DONE directly, with valid one cycle after the start edge; when FAST_SPECIAL=0, take them through the full-latency path.
REQ-024 SHALL hold result stable from DONE until the next accepted start.
REQ-025 SHALL, on abort=1 in RUN or DONE, return to IDLE next edge with no valid pulse and result unchanged; abort has priority over DONE.
REQ-026 SHALL ignore abort in IDLE; abort and start together in IDLE SHALL NOT start an operation.
REQ-027 SHALL size the iteration counter as clog2(XLEN)+1 bits, with no wrap before terminal count.

Reset
REQ-028 SHALL, on reset_n low at any time including mid-operation, immediately force state IDLE, busy=0, valid=0, result=0 and counter=0.
REQ-029 SHALL accept a start on the first rising edge after reset_n deasserts.

Structure
REQ-030 SHALL place funct3 encodings, state encoding and the op-flag record (signed_a, signed_b, take_high, is_div, is_rem) in a shared package mdu_pkg.
REQ-031 SHALL use one combinational sub-module, mdu_op_decoder, to map funct3 to op flags; the datapath and FSM stay in mdu_sequencer.

Verification (XLEN=32)
REQ-032 SHALL verify MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, valid exactly 33 cycles after start, busy high 33 cycles.
REQ-033 SHALL verify MULH and MULHU with 0x80000000 x 0x80000000 -> 0x40000000 for both; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-034 SHALL verify DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 0x00000005, with valid 1 cycle after start (FAST_SPECIAL=1); DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same -> 0; DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF.
REQ-035 SHALL verify abort asserted on the 10th RUN cycle -> no valid, busy low next cycle, and a fresh DIVU 100/7 -> 14 completes normally.
REQ-036 SHALL verify start pulsed mid-RUN with different operands -> ignored, and the original result delivered.
REQ-037 SHALL verify reset_n asserted mid-RUN -> outputs zero immediately, and no valid after release.
